// File: rtl/main_pkg.sv
// -----------------------------------------------------------------------------
// main_pkg
// Definitions shared by the dot-product accelerator: vector and bus sizes,
// the control FSM state encoding and the multiply-accumulate helper.
// -----------------------------------------------------------------------------
package main_pkg;

    localparam int N      = 16;  // vector length
    localparam int ADDR_W = 4;   // load address width, 2**ADDR_W must cover N
    localparam int DATA_W = 32;  // element, product and accumulator width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        WAIT_DONE,
        FIN
    } state_e;

    // Low DATA_W bits of acc + a*b. Truncated two's-complement arithmetic
    // gives the same bits for signed and unsigned operands.
    function automatic logic [DATA_W-1:0] mac(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] prod;
        prod = a * b;
        return acc + prod;
    endfunction

endpackage

// File: rtl/main_ld_port.sv
// -----------------------------------------------------------------------------
// main_ld_port
// One load channel of the dot-product engine. For the current index it issues
// a single address, then captures the returned element and remembers that it
// holds it until the engine consumes the pair.
//
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   active_i         engine is in its load phase
//   clear_i          element consumed; rearm for the next index
//   index_i          element index to fetch
//   addr_o/addr_valid_o/addr_ready_i   address channel to memory
//   data_i/data_valid_i/data_ready_o   data channel from memory
//   elem_o           element for the current index (captured or passing through)
//   have_o           elem_o is valid this cycle
// -----------------------------------------------------------------------------
module main_ld_port
    import main_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              active_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] index_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] elem_o,
    output logic              have_o
);

    logic              addr_sent_q, addr_sent_d;
    logic              got_q, got_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              data_xfer;

    assign addr_o       = index_i;
    assign addr_valid_o = active_i & ~addr_sent_q;
    assign data_ready_o = active_i & ~got_q;
    assign data_xfer    = data_valid_i & data_ready_o;

    // A same-cycle data return (combinational memory) is forwarded directly so
    // the engine can consume one element per cycle.
    assign have_o = got_q | data_xfer;
    assign elem_o = got_q ? data_q : data_i;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned and no latch is inferred.
        addr_sent_d = addr_sent_q;
        got_d       = got_q;
        data_d      = data_q;
        if (clear_i) begin
            addr_sent_d = 1'b0;
            got_d       = 1'b0;
        end else begin
            if (addr_valid_o && addr_ready_i) addr_sent_d = 1'b1;
            if (data_xfer) begin
                got_d  = 1'b1;
                data_d = data_i;
            end
        end
    end

    // NOTE: state registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_sent_q <= 1'b0;
            got_q       <= 1'b0;
            // NOTE: the data register is reset only so elem_o is never X; got_q alone qualifies its use.
            data_q      <= '0;
        end else begin
            addr_sent_q <= addr_sent_d;
            got_q       <= got_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: rtl/main_dot16.sv
// -----------------------------------------------------------------------------
// main_dot16
// Dot-product accelerator: on a start token it loads N elements from memory A
// and memory B, accumulates sum(a[i]*b[i]) modulo 2**DATA_W, stores the scalar
// result, waits for the store-complete token and emits a completion token.
//
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   in3_valid/in3_ready                   start token
//   in0_ld0_* / in1_ld0_*                 load ports for memories A / B
//   in2_st0, in2_st0_valid/_ready         result store
//   in2_st0_done_valid/_ready             store-complete token
//   out0_valid/out0_ready                 completion token
// -----------------------------------------------------------------------------
module main_dot16
    import main_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in3_valid,
    output logic              in3_ready,
    output logic [ADDR_W-1:0] in0_ld0_addr,
    output logic              in0_ld0_addr_valid,
    input  logic              in0_ld0_addr_ready,
    input  logic [DATA_W-1:0] in0_ld0_data,
    input  logic              in0_ld0_data_valid,
    output logic              in0_ld0_data_ready,
    output logic [ADDR_W-1:0] in1_ld0_addr,
    output logic              in1_ld0_addr_valid,
    input  logic              in1_ld0_addr_ready,
    input  logic [DATA_W-1:0] in1_ld0_data,
    input  logic              in1_ld0_data_valid,
    output logic              in1_ld0_data_ready,
    output logic [DATA_W-1:0] in2_st0,
    output logic              in2_st0_valid,
    input  logic              in2_st0_ready,
    input  logic              in2_st0_done_valid,
    output logic              in2_st0_done_ready,
    output logic              out0_valid,
    input  logic              out0_ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic              load_active;
    logic              have_a, have_b, mac_fire;
    logic [DATA_W-1:0] elem_a, elem_b;

    assign load_active = (state_q == LOAD);
    assign mac_fire    = load_active & have_a & have_b;

    main_ld_port u_ld_a (
        .clock        (clock),
        .reset        (reset),
        .active_i     (load_active),
        .clear_i      (mac_fire),
        .index_i      (index_q),
        .addr_o       (in0_ld0_addr),
        .addr_valid_o (in0_ld0_addr_valid),
        .addr_ready_i (in0_ld0_addr_ready),
        .data_i       (in0_ld0_data),
        .data_valid_i (in0_ld0_data_valid),
        .data_ready_o (in0_ld0_data_ready),
        .elem_o       (elem_a),
        .have_o       (have_a)
    );

    main_ld_port u_ld_b (
        .clock        (clock),
        .reset        (reset),
        .active_i     (load_active),
        .clear_i      (mac_fire),
        .index_i      (index_q),
        .addr_o       (in1_ld0_addr),
        .addr_valid_o (in1_ld0_addr_valid),
        .addr_ready_i (in1_ld0_addr_ready),
        .data_i       (in1_ld0_data),
        .data_valid_i (in1_ld0_data_valid),
        .data_ready_o (in1_ld0_data_ready),
        .elem_o       (elem_b),
        .have_o       (have_b)
    );

    // Handshake outputs decode the state register only, so none of them
    // depends combinationally on an input.
    assign in3_ready          = (state_q == IDLE);
    assign in2_st0            = acc_q;
    assign in2_st0_valid      = (state_q == STORE);
    assign in2_st0_done_ready = (state_q == WAIT_DONE);
    assign out0_valid         = (state_q == FIN);

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in3_valid) begin
                    acc_d   = '0;
                    index_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (mac_fire) begin
                    acc_d = mac(acc_q, elem_a, elem_b);
                    // The last index is held; the next start clears it.
                    if (index_q == ADDR_W'(N - 1)) state_d = STORE;
                    else                           index_d = index_q + ADDR_W'(1);
                end
            end
            STORE:     if (in2_st0_ready)      state_d = WAIT_DONE;
            WAIT_DONE: if (in2_st0_done_valid) state_d = FIN;
            FIN:       if (out0_ready)         state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_main_dot16.sv
// -----------------------------------------------------------------------------
// tb_main_dot16
// Self-checking bench for main_dot16. Two behavioural memories (configurable
// read latency and randomly stalling address channels) feed the load ports;
// results are compared against a dot product computed with plain 64-bit
// arithmetic from the vectors written into those memories.
// -----------------------------------------------------------------------------
module tb_main_dot16;

    localparam int NV = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [3:0]  ld_addr       [2];
    logic        ld_addr_valid [2];
    logic        ld_addr_ready [2];
    logic [31:0] ld_data       [2];
    logic        ld_data_valid [2];
    logic        ld_data_ready [2];
    logic [31:0] in2_st0;
    logic        in2_st0_valid;
    logic        in2_st0_ready = 1'b0;
    logic        in2_st0_done_valid = 1'b0;
    logic        in2_st0_done_ready;
    logic        out0_valid;
    logic        out0_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    main_dot16 dut (
        .clock              (clock),
        .reset              (reset),
        .in3_valid          (in3_valid),
        .in3_ready          (in3_ready),
        .in0_ld0_addr       (ld_addr[0]),
        .in0_ld0_addr_valid (ld_addr_valid[0]),
        .in0_ld0_addr_ready (ld_addr_ready[0]),
        .in0_ld0_data       (ld_data[0]),
        .in0_ld0_data_valid (ld_data_valid[0]),
        .in0_ld0_data_ready (ld_data_ready[0]),
        .in1_ld0_addr       (ld_addr[1]),
        .in1_ld0_addr_valid (ld_addr_valid[1]),
        .in1_ld0_addr_ready (ld_addr_ready[1]),
        .in1_ld0_data       (ld_data[1]),
        .in1_ld0_data_valid (ld_data_valid[1]),
        .in1_ld0_data_ready (ld_data_ready[1]),
        .in2_st0            (in2_st0),
        .in2_st0_valid      (in2_st0_valid),
        .in2_st0_ready      (in2_st0_ready),
        .in2_st0_done_valid (in2_st0_done_valid),
        .in2_st0_done_ready (in2_st0_done_ready),
        .out0_valid         (out0_valid),
        .out0_ready         (out0_ready)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [2][NV];
    int          lat [2];          // 0 = combinational, k = data k cycles after address
    bit          rand_ardy [2];    // randomly stall the address channel
    logic        pend_valid [2];
    logic [3:0]  pend_addr  [2];
    int          pend_wait  [2];
    int          addr_log0 [$];
    int          addr_log1 [$];
    int          store_valid_edges = 0;

    initial begin
        lat[0] = 0; lat[1] = 0;
        rand_ardy[0] = 1'b0; rand_ardy[1] = 1'b0;
    end

    always @(negedge clock) begin
        for (int s = 0; s < 2; s++)
            ld_addr_ready[s] = rand_ardy[s] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ld_data_valid[s] = 1'b0;
            ld_data[s]       = '0;
            if (lat[s] == 0) begin
                ld_data_valid[s] = ld_addr_valid[s] && ld_addr_ready[s];
                ld_data[s]       = mem[s][ld_addr[s]];
            end else if (pend_valid[s] === 1'b1) begin
                ld_data_valid[s] = (pend_wait[s] == 0);
                ld_data[s]       = mem[s][pend_addr[s]];
            end
        end
    end

    always @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                pend_valid[s] <= 1'b0;
                pend_wait[s]  <= 0;
            end else if (lat[s] > 0) begin
                if (pend_valid[s] && pend_wait[s] == 0 && ld_data_ready[s])
                    pend_valid[s] <= 1'b0;
                else if (pend_valid[s] && pend_wait[s] > 0)
                    pend_wait[s] <= pend_wait[s] - 1;
                if (ld_addr_valid[s] && ld_addr_ready[s]) begin
                    pend_valid[s] <= 1'b1;
                    pend_addr[s]  <= ld_addr[s];
                    pend_wait[s]  <= lat[s] - 1;
                end
            end
        end
        if (!reset && ld_addr_valid[0] && ld_addr_ready[0]) addr_log0.push_back(int'(ld_addr[0]));
        if (!reset && ld_addr_valid[1] && ld_addr_ready[1]) addr_log1.push_back(int'(ld_addr[1]));
        if (!reset && in2_st0_valid) store_valid_edges <= store_valid_edges + 1;
    end

    // ---------------- reference model and helpers ----------------
    function automatic logic [31:0] ref_dot(input logic [31:0] a [NV], input logic [31:0] b [NV]);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < NV; i++)
            s = (s + 64'(a[i]) * 64'(b[i])) % 64'h1_0000_0000;
        return s[31:0];
    endfunction

    // Index of the first out-of-order address, NV if too few, -1 if 0..NV-1 exactly.
    function automatic int first_bad(input int q [$]);
        for (int i = 0; i < q.size(); i++)
            if (i >= NV || q[i] != i) return i;
        return (q.size() == NV) ? -1 : NV;
    endfunction

    task automatic load_vec(input logic [31:0] a [NV], input logic [31:0] b [NV]);
        for (int i = 0; i < NV; i++) begin
            mem[0][i] = a[i];
            mem[1][i] = b[i];
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        in3_valid = 1'b0; in2_st0_ready = 1'b0; in2_st0_done_valid = 1'b0; out0_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Runs one start-to-completion transaction and checks the handshake protocol.
    task automatic do_transaction(input int st_hold, input int done_delay,
                                  output logic [31:0] res, output int lat_cyc, output bit ok);
        ok = 1'b1; res = '0; lat_cyc = 0;
        addr_log0.delete(); addr_log1.delete();
        @(negedge clock);
        n_checks++;
        if (in3_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready: got %b want 1", in3_ready); end
        in3_valid = 1'b1;
        @(negedge clock);
        in3_valid = 1'b0;
        n_checks++;
        if (in3_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", in3_ready); end
        while (in2_st0_valid !== 1'b1 && lat_cyc < 400) begin
            @(negedge clock);
            lat_cyc++;
        end
        if (in2_st0_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL store_timeout: no in2_st0_valid within %0d cycles", lat_cyc);
            ok = 1'b0;
            apply_reset();
            return;
        end
        res = in2_st0;
        in2_st0_ready = (st_hold == 0);
        for (int k = 0; k < st_hold; k++) begin
            @(negedge clock);
            n_checks++;
            if (in2_st0_valid !== 1'b1 || in2_st0 !== res) begin
                n_fail++;
                $display("FAIL store_hold: valid=%b data=%h want valid=1 data=%h", in2_st0_valid, in2_st0, res);
            end
        end
        in2_st0_ready = 1'b1;
        @(negedge clock);
        in2_st0_ready = 1'b0;
        n_checks++;
        if ({in2_st0_valid, in2_st0_done_ready, out0_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL store_release: {st_valid,done_ready,out0_valid}=%b want 010",
                     {in2_st0_valid, in2_st0_done_ready, out0_valid});
        end
        repeat (done_delay) @(negedge clock);
        in2_st0_done_valid = 1'b1;
        @(negedge clock);
        in2_st0_done_valid = 1'b0;
        n_checks++;
        if ({out0_valid, in2_st0_done_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fin_entry: {out0_valid,done_ready}=%b want 10", {out0_valid, in2_st0_done_ready});
        end
        @(negedge clock);
        n_checks++;
        if (out0_valid !== 1'b1) begin n_fail++; $display("FAIL fin_hold: out0_valid=%b want 1", out0_valid); end
        out0_ready = 1'b1;
        @(negedge clock);
        out0_ready = 1'b0;
        n_checks++;
        if ({out0_valid, in3_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL back_to_idle: {out0_valid,in3_ready}=%b want 01", {out0_valid, in3_ready});
        end
    endtask

    // Snapshot of every output that reset defines.
    function automatic logic [47:0] out_snapshot();
        return {in3_ready, ld_addr_valid[0], ld_addr_valid[1], ld_data_ready[0], ld_data_ready[1],
                in2_st0_valid, in2_st0_done_ready, out0_valid, ld_addr[0], ld_addr[1], in2_st0};
    endfunction

    localparam logic [47:0] RESET_OUTS = {8'b1000_0000, 4'd0, 4'd0, 32'd0};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (out_snapshot() !== RESET_OUTS) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", out_snapshot(), RESET_OUTS);
        end
    endtask

    // Runs a fixed vector and compares with a required constant.
    task automatic run_fixed(input string name, input logic [31:0] a [NV], input logic [31:0] b [NV],
                             input logic [31:0] want, input bit check_timing);
        logic [31:0] res; int cyc; bit ok; int edges0;
        load_vec(a, b);
        edges0 = store_valid_edges;
        do_transaction(0, 0, res, cyc, ok);
        if (!ok) return;
        n_checks++;
        if (res !== want) begin n_fail++; $display("FAIL %s: result %h want %h", name, res, want); end
        if (check_timing) begin
            n_checks++;
            if (cyc > NV + 2) begin n_fail++; $display("FAIL %s_latency: %0d cycles want <= %0d", name, cyc, NV + 2); end
            n_checks++;
            if (store_valid_edges - edges0 != 1) begin
                n_fail++; $display("FAIL %s_store_pulse: %0d valid cycles want 1", name, store_valid_edges - edges0);
            end
        end
    endtask

    task automatic test_patterns();
        logic [31:0] a [NV]; logic [31:0] b [NV];
        for (int i = 0; i < NV; i++) begin a[i] = 32'(i + 1); b[i] = 32'd1; end
        run_fixed("ramp", a, b, 32'd136, 1'b1);
        for (int i = 0; i < NV; i++) begin a[i] = 32'(i); b[i] = 32'(i); end
        run_fixed("square", a, b, 32'd1240, 1'b1);
        for (int i = 0; i < NV; i++) begin a[i] = 32'hFFFF_FFFF; b[i] = 32'd5; end
        run_fixed("negative", a, b, 32'hFFFF_FFB0, 1'b0);
        for (int i = 0; i < NV; i++) begin a[i] = 32'h0001_0000; b[i] = 32'h0001_0000; end
        run_fixed("wrap", a, b, 32'd0, 1'b0);
    endtask

    task automatic test_mem_stall();
        logic [31:0] a [NV]; logic [31:0] b [NV];
        logic [31:0] res; int cyc; bit ok; int bad0, bad1;
        for (int i = 0; i < NV; i++) begin a[i] = 32'(i + 1); b[i] = 32'd1; end
        load_vec(a, b);
        rand_ardy[0] = 1'b1; lat[1] = 3;
        do_transaction(0, 1, res, cyc, ok);
        rand_ardy[0] = 1'b0; lat[1] = 0;
        if (!ok) return;
        n_checks++;
        if (res !== 32'd136) begin n_fail++; $display("FAIL stall_result: %h want %h", res, 32'd136); end
        bad0 = first_bad(addr_log0);
        bad1 = first_bad(addr_log1);
        n_checks++;
        if (bad0 != -1 || bad1 != -1) begin
            n_fail++;
            $display("FAIL stall_addr_order: first bad A=%0d B=%0d (A %0d loads, B %0d loads) want -1/-1",
                     bad0, bad1, addr_log0.size(), addr_log1.size());
        end
    endtask

    task automatic test_random(input int iters, input int st_hold);
        logic [31:0] a [NV]; logic [31:0] b [NV];
        logic [31:0] res, want; int cyc; bit ok; int bad0, bad1;
        for (int t = 0; t < iters; t++) begin
            for (int i = 0; i < NV; i++) begin a[i] = $urandom; b[i] = $urandom; end
            load_vec(a, b);
            want = ref_dot(a, b);
            lat[0] = int'($urandom_range(0, 3)); lat[1] = int'($urandom_range(0, 3));
            rand_ardy[0] = 1'($urandom_range(0, 1)); rand_ardy[1] = 1'($urandom_range(0, 1));
            do_transaction(st_hold < 0 ? int'($urandom_range(0, 3)) : st_hold, int'($urandom_range(0, 3)), res, cyc, ok);
            if (ok) begin
                n_checks++;
                if (res !== want) begin n_fail++; $display("FAIL random_result[%0d]: %h want %h", t, res, want); end
                bad0 = first_bad(addr_log0);
                bad1 = first_bad(addr_log1);
                n_checks++;
                if (bad0 != -1 || bad1 != -1) begin
                    n_fail++; $display("FAIL random_addr_order[%0d]: first bad A=%0d B=%0d want -1/-1", t, bad0, bad1);
                end
            end
        end
        lat[0] = 0; lat[1] = 0; rand_ardy[0] = 1'b0; rand_ardy[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a [NV]; logic [31:0] b [NV];
        logic [31:0] res; int cyc; bit ok; int edges0; int wait_cyc;
        for (int i = 0; i < NV; i++) begin a[i] = 32'(i + 1); b[i] = 32'd1; end
        load_vec(a, b);
        @(negedge clock);
        in3_valid = 1'b1;
        @(negedge clock);
        in3_valid = 1'b0;
        wait_cyc = 0;
        while (ld_addr[0] !== 4'd7 && wait_cyc < 100) begin @(negedge clock); wait_cyc++; end
        n_checks++;
        if (ld_addr[0] !== 4'd7) begin n_fail++; $display("FAIL mid_reach_index7: addr %h want 7", ld_addr[0]); end
        edges0 = store_valid_edges;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (out_snapshot() !== RESET_OUTS) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h want %h", out_snapshot(), RESET_OUTS);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (store_valid_edges != edges0 || in3_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_no_store: %0d stray store cycles, in3_ready=%b want 0 and 1",
                               store_valid_edges - edges0, in3_ready);
        end
        do_transaction(0, 0, res, cyc, ok);
        if (!ok) return;
        n_checks++;
        if (res !== 32'd136) begin n_fail++; $display("FAIL after_reset_result: %h want %h", res, 32'd136); end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_mem_stall();
        test_random(1, 5);    // store back-pressure: ready low for 5 cycles
        test_random(4, -1);   // random data, latencies, stalls and store waits
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
